// File: rtl/ctrl_link_pkg.sv
// ctrl_link_pkg: shared constants and types for the player-2 controller link
// receiver.
//   FRAME_DATA_BITS      number of button bits carried per frame
//   BTN_*_IDX            position of each button in the received data word
//   rx_state_t           receiver FSM states
//   even_parity()        parity bit the sender attaches to a data word
package ctrl_link_pkg;

  localparam int FRAME_DATA_BITS = 5;

  localparam int BTN_UP_IDX     = 0;
  localparam int BTN_DOWN_IDX   = 1;
  localparam int BTN_LEFT_IDX   = 2;
  localparam int BTN_RIGHT_IDX  = 3;
  localparam int BTN_ATTACK_IDX = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [FRAME_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/ctrl_link_bit_timer.sv
// ctrl_link_bit_timer: free-running bit-period counter for the link receiver.
//   clk, reset  system clock, asynchronous active-high reset
//   clear       holds the counter at zero (next cycle starts a fresh period)
//   mid_bit     high for one cycle, CLKS_PER_BIT/2 cycles after the clear
//   end_bit     high for one cycle every CLKS_PER_BIT cycles after the clear
// Strobes depend on the count only, so the owner may derive clear from
// mid_bit without creating a combinational loop.
module ctrl_link_bit_timer #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic mid_bit,
  output logic end_bit
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (clear || cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  assign mid_bit = (cnt == MID);
  assign end_bit = (cnt == LAST);

endmodule

// File: rtl/ctrl_link_rx.sv
// ctrl_link_rx: master-board receiver for the serialized player-2 controller.
// Frame (LSB first): start(0), up, down, left, right, attack, even parity,
// stop(1). Good frames become registered button levels; a silent link for
// TIMEOUT_CLKS cycles drops link_up and releases every button.
//   clk, reset          100 MHz clock, asynchronous active-high reset
//   rx_serial           raw line from the slave board (idle high, async)
//   btn_up..btn_attack  recovered button levels
//   frame_valid         1-cycle pulse per accepted frame
//   parity_err          1-cycle pulse, parity mismatch
//   framing_err         1-cycle pulse, stop bit sampled low
//   link_up             high while good frames keep arriving
// Build option: define CTRL_LINK_DEBOUNCE_EN to require two identical good
// frames in a row before the buttons change.
module ctrl_link_rx
  import ctrl_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int TIMEOUT_CLKS = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic rx_serial,
  output logic btn_up,
  output logic btn_down,
  output logic btn_left,
  output logic btn_right,
  output logic btn_attack,
  output logic frame_valid,
  output logic parity_err,
  output logic framing_err,
  output logic link_up
);

  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_CLKS);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CLKS - 1);
  localparam logic [2:0]    LAST_DATA = 3'(FRAME_DATA_BITS - 1);

  // Two-flop synchronizer; flops reset to the idle level.
  logic rx_meta, rx_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx_serial;
      rx_sync <= rx_meta;
    end
  end

  rx_state_t                  state;
  logic [2:0]                 bit_cnt;
  logic [FRAME_DATA_BITS-1:0] shreg;
  logic                       par_bit;
  logic                       mid_bit, end_bit, tmr_clear;
  logic                       parity_ok, good;

  // Timer sits at zero while waiting for a start bit, and is re-zeroed at the
  // start-bit midpoint so every later end_bit lands mid-bit.
  assign tmr_clear = (state == IDLE) || (state == WAIT_IDLE) ||
                     (state == START && mid_bit);

  ctrl_link_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear),
    .mid_bit (mid_bit),
    .end_bit (end_bit)
  );

  assign parity_ok = (even_parity(shreg) == par_bit);
  assign good      = (state == STOP) && end_bit && rx_sync && parity_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      par_bit     <= 1'b0;
      frame_valid <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      case (state)
        // IDLE is only entered with the line last seen high (good stop bit,
        // rejected glitch, WAIT_IDLE exit, reset), so a low level here is a
        // falling edge. Checking the level keeps back-to-back frames whose
        // start bit arrives right after the stop midpoint.
        IDLE: if (!rx_sync) state <= START;
        START: if (mid_bit) begin
          bit_cnt <= '0;
          state   <= rx_sync ? IDLE : DATA;
        end
        DATA: if (end_bit) begin
          shreg <= {rx_sync, shreg[FRAME_DATA_BITS-1:1]};
          if (bit_cnt == LAST_DATA) state <= PARITY;
          else bit_cnt <= bit_cnt + 1'b1;
        end
        PARITY: if (end_bit) begin
          par_bit <= rx_sync;
          state   <= STOP;
        end
        STOP: if (end_bit) begin
          if (rx_sync) begin
            frame_valid <= parity_ok;
            parity_err  <= !parity_ok;
            state       <= IDLE;
          end else begin
            framing_err <= 1'b1;
            state       <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: if (rx_sync) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Button levels and link health. A good frame takes priority over timeout
  // expiry in the same cycle.
  logic [TW-1:0]              tcnt;
  logic [FRAME_DATA_BITS-1:0] btn_q;
`ifdef CTRL_LINK_DEBOUNCE_EN
  logic [FRAME_DATA_BITS-1:0] cand;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt    <= '0;
      link_up <= 1'b0;
      btn_q   <= '0;
`ifdef CTRL_LINK_DEBOUNCE_EN
      cand    <= '0;
`endif
    end else if (good) begin
      tcnt    <= '0;
      link_up <= 1'b1;
`ifdef CTRL_LINK_DEBOUNCE_EN
      // Only a repeat of the previous good frame reaches the buttons.
      cand <= shreg;
      if (shreg == cand) btn_q <= shreg;
`else
      btn_q <= shreg;
`endif
    end else if (tcnt != T_MAX) begin
      tcnt <= tcnt + 1'b1;
      if (tcnt == T_LAST) begin
        link_up <= 1'b0;
        btn_q   <= '0;
`ifdef CTRL_LINK_DEBOUNCE_EN
        cand    <= '0;
`endif
      end
    end
  end

  assign btn_up     = btn_q[BTN_UP_IDX];
  assign btn_down   = btn_q[BTN_DOWN_IDX];
  assign btn_left   = btn_q[BTN_LEFT_IDX];
  assign btn_right  = btn_q[BTN_RIGHT_IDX];
  assign btn_attack = btn_q[BTN_ATTACK_IDX];

endmodule
